// File: rtl/alu_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_arbiter_pkg
// Purpose  : Shared opcodes, FSM encoding and width default for alu_rr_arbiter
// Revision : 1.0  initial release
// ============================================================================
package alu_rr_arbiter_pkg;

    localparam int DATA_W_DEFAULT = 4;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_t;

    // Only the arithmetic opcodes can produce a meaningful overflow flag.
    function automatic logic op_reports_overflow(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage : alu_rr_arbiter_pkg
`default_nettype wire

// File: rtl/alu_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_pick
// Purpose  : Combinational two-input round-robin picker
// Revision : 1.0  initial release
// ============================================================================
module alu_rr_pick
    import alu_rr_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |valid;
        // Under contention the requester that did not win last time goes next.
        if (&valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = valid[1];
        end
    end

endmodule : alu_rr_pick
`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_arbiter
// Purpose  : Two-requester round-robin sequencer for a shared 4-bit ALU.
//            Optional sticky overflow flag: define ALU_ARB_ERR_STICKY_EN.
// Revision : 1.0  initial release
// ============================================================================
module alu_rr_arbiter
    import alu_rr_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,

    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_error,

    output logic              err_sticky,
    input  logic              err_clr
);

    arb_state_t state;
    arb_state_t state_next;
    logic       last_grant;
    logic       grant_valid;
    logic       grant_id;
    logic       accept;
    logic       capture_err;

    alu_rr_pick u_pick (
        .valid       ({req1_valid, req0_valid}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign accept      = (state == ST_IDLE) && grant_valid;
    assign req0_ready  = accept && !grant_id;
    assign req1_ready  = accept &&  grant_id;
    assign resp_valid  = (state == ST_RESP);
    assign capture_err = alu_error && op_reports_overflow(alu_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant_valid) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (resp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operands drive the ALU straight from flops so it never sees requester glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            resp_id    <= 1'b0;
            alu_op     <= 2'b00;
            alu_in1    <= '0;
            alu_in2    <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant_id;
                resp_id    <= grant_id;
                alu_op     <= grant_id ? req1_op : req0_op;
                alu_in1    <= grant_id ? req1_a  : req0_a;
                alu_in2    <= grant_id ? req1_b  : req0_b;
            end
            if (state == ST_EXEC) begin
                resp_data <= alu_out;
                resp_err  <= capture_err;
            end
        end
    end

`ifdef ALU_ARB_ERR_STICKY_EN
    logic sticky;

    // Setting on the RESP entry edge takes priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= 1'b0;
        end else if ((state == ST_EXEC) && capture_err) begin
            sticky <= 1'b1;
        end else if (err_clr) begin
            sticky <= 1'b0;
        end
    end

    assign err_sticky = sticky;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err_sticky     = 1'b0;
`endif

endmodule : alu_rr_arbiter
`default_nettype wire
